spi_cfg_master: RTL and testbench

SPI controller that configures the chip's SPI-mapped control registers (output enables, PWM enables, PWM duty cycle). Two on-chip requesters present write requests. A round-robin arbiter shares the single SPI link between them, and each granted request is serialised into one 16-bit write frame on `spi_sclk`, `spi_copi` and `spi_nCS`. It sits between the on-chip requesters and the SPI register peripheral.

---
 rtl/spi_cfg_pkg.sv | 20 ++
 rtl/spi_cfg_if.sv | 17 +
 rtl/spi_phase_timer.sv | 15 +
 rtl/spi_cfg_master.sv | 104 ++++++++++
 tb/tb_spi_cfg_master.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: FSM states, frame layout and SPI register map shared by the SPI config master
package spi_cfg_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  localparam int WR_BIT   = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;
  function automatic logic [15:0] make_frame(input logic [6:0] addr, input logic [7:0] data);
    logic [15:0] f;
    f = '0;
    f[WR_BIT] = 1'b1;
    f[ADDR_MSB:ADDR_LSB] = addr;
    f[ADDR_LSB-1:0] = data;
    return f;
  endfunction
endpackage

// File: rtl/spi_cfg_if.sv
// spi_cfg_if: requester handshake plus SPI pins of the config master
interface spi_cfg_if;
  logic [1:0]  req_valid;
  logic [13:0] req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        busy;
  logic        done;
  logic        done_id;
  logic        spi_sclk;
  logic        spi_copi;
  logic        spi_nCS;
  modport master (input req_valid, req_addr, req_data,
                  output req_ready, busy, done, done_id, spi_sclk, spi_copi, spi_nCS);
  modport slave  (output req_valid, req_addr, req_data,
                  input req_ready, busy, done, done_id, spi_sclk, spi_copi, spi_nCS);
endinterface

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable 8-bit down-counter, tc high while the count sits at zero
module spi_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       tc
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 8'd1;
  assign tc = cnt == '0;
endmodule

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: round-robin arbitrated 16-bit SPI write-frame master for the chip config registers
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input logic       clk,
  input logic       rst_n,
  spi_cfg_if.master bus
);
  state_t      state, state_nxt;
  logic        ptr, ptr_nxt, id, id_nxt;
  logic        sclk_q, sclk_nxt, copi_q, copi_nxt, ncs_q, ncs_nxt, done_q, done_nxt;
  logic [15:0] shreg, shreg_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [1:0]  gnt;
  logic        load, tc;
  logic [7:0]  load_val;
  assign gnt = {bus.req_valid[1] & (~bus.req_valid[0] | ptr),
                bus.req_valid[0] & (~bus.req_valid[1] | ~ptr)};
  assign load_val = (state_nxt == GAP) ? 8'(GAP_CYCLES - 1) : 8'(CLK_DIV - 1);
  spi_phase_timer u_timer (.clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .tc(tc));
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    id_nxt        = id;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    sclk_nxt      = sclk_q;
    copi_nxt      = copi_q;
    ncs_nxt       = ncs_q;
    done_nxt      = 1'b0;
    load          = 1'b0;
    bus.req_ready = 2'b00;
    case (state)
      IDLE: if (gnt != 2'b00) begin
        bus.req_ready = gnt;
        load          = 1'b1;
        id_nxt        = gnt[1];
        ptr_nxt       = ~gnt[1];
        shreg_nxt     = make_frame(gnt[1] ? bus.req_addr[13:7] : bus.req_addr[6:0],
                                   gnt[1] ? bus.req_data[15:8] : bus.req_data[7:0]);
        copi_nxt      = shreg_nxt[WR_BIT];
        ncs_nxt       = 1'b0;
        bit_cnt_nxt   = '0;
        state_nxt     = LEAD;
      end
      LEAD: if (tc) begin
        load      = 1'b1;
        sclk_nxt  = 1'b1;
        state_nxt = SHIFT;
      end
      // sclk_q tells high from low phase; a high phase ending advances to the next bit
      SHIFT: if (tc) begin
        load     = 1'b1;
        sclk_nxt = ~sclk_q;
        if (sclk_q && bit_cnt == 4'd15) state_nxt = TRAIL;
        else if (sclk_q) begin
          shreg_nxt   = {shreg[14:0], 1'b0};
          copi_nxt    = shreg[14];
          bit_cnt_nxt = bit_cnt + 4'd1;
        end
      end
      TRAIL: if (tc) begin
        load      = 1'b1;
        ncs_nxt   = 1'b1;
        copi_nxt  = 1'b0;
        done_nxt  = 1'b1;
        state_nxt = GAP;
      end
      GAP: if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      id      <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      sclk_q  <= 1'b0;
      copi_q  <= 1'b0;
      ncs_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      id      <= id_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      sclk_q  <= sclk_nxt;
      copi_q  <= copi_nxt;
      ncs_q   <= ncs_nxt;
      done_q  <= done_nxt;
    end
  assign bus.busy     = state != IDLE;
  assign bus.done     = done_q;
  assign bus.done_id  = id;
  assign bus.spi_sclk = sclk_q;
  assign bus.spi_copi = copi_q;
  assign bus.spi_nCS  = ncs_q;
endmodule

// File: tb/tb_spi_cfg_master.sv
// tb_spi_cfg_master: directed and random write frames checked against a peripheral/arbiter model
module tb_spi_cfg_master;
  import spi_cfg_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_cfg_if b0 ();
  spi_cfg_if b1 ();
  spi_cfg_master dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
  spi_cfg_master #(.CLK_DIV(2), .GAP_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));
  // Bus monitor plus behavioural SPI register peripheral, one per DUT
  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int CD = g ? 2 : 4;
    logic ncs, sclk, copi, done, did, bsy;
    logic [1:0] rdy;
    assign ncs = g ? b1.spi_nCS : b0.spi_nCS;
    assign sclk = g ? b1.spi_sclk : b0.spi_sclk;
    assign copi = g ? b1.spi_copi : b0.spi_copi;
    assign done = g ? b1.done : b0.done;
    assign did = g ? b1.done_id : b0.done_id;
    assign bsy = g ? b1.busy : b0.busy;
    assign rdy = g ? b1.req_ready : b0.req_ready;
    logic [15:0] sh = '0;
    logic p_ncs = 1'b1, p_sclk = 1'b0, p_copi = 1'b0;
    int nbits = 0, low_len = 0, high_len = 0, run = 0;
    int bad_phase = 0, bad_copi = 0, bad_done = 0, bad_ready = 0;
    int frames[$], lens[$], gaps[$], dids[$], grants[$];
    logic [7:0] preg [128];
    always @(negedge clk) begin
      if (rdy != 2'b00) begin
        grants.push_back(int'(rdy[1]));
        if (bsy || rdy == 2'b11) bad_ready++;
      end
      if (done) begin
        dids.push_back(int'(did));
        if (!(ncs && !p_ncs)) bad_done++;
      end
      if (!ncs) begin
        if (p_ncs) begin
          gaps.push_back(high_len);
          low_len = 0;
          nbits = 0;
          run = 0;
        end else if (sclk != p_sclk) begin
          if (run != CD) bad_phase++;
          run = 0;
        end
        if (sclk && !p_sclk) begin
          sh = {sh[14:0], copi};
          nbits++;
        end
        if (sclk && copi != p_copi) bad_copi++;
        low_len++;
        run++;
      end else begin
        if (!p_ncs) begin
          frames.push_back((nbits << 16) | int'(sh));
          lens.push_back(low_len);
          high_len = 0;
          if (rst_n && run != CD) bad_phase++;
          if (nbits == 16 && sh[15]) preg[sh[14:8]] = sh[7:0];
        end
        high_len++;
      end
      p_ncs = ncs;
      p_sclk = sclk;
      p_copi = copi;
    end
  end
  int passed = 0, fails = 0, total = 0;
  int bf, bd, bg, bgp;
  logic mptr [2] = '{1'b0, 1'b0};
  logic [7:0] mreg [2][128];
  int exp_fr[$], exp_id[$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int qs(input int g, input int w);
    if (g == 0)
      case (w)
        0: return mon[0].frames.size();
        2: return mon[0].gaps.size();
        3: return mon[0].dids.size();
        default: return mon[0].grants.size();
      endcase
    case (w)
      0: return mon[1].frames.size();
      2: return mon[1].gaps.size();
      3: return mon[1].dids.size();
      default: return mon[1].grants.size();
    endcase
  endfunction
  function automatic int q(input int g, input int w, input int i);
    if (g == 0)
      case (w)
        0: return mon[0].frames[i];
        1: return mon[0].lens[i];
        2: return mon[0].gaps[i];
        3: return mon[0].dids[i];
        default: return mon[0].grants[i];
      endcase
    case (w)
      0: return mon[1].frames[i];
      1: return mon[1].lens[i];
      2: return mon[1].gaps[i];
      3: return mon[1].dids[i];
      default: return mon[1].grants[i];
    endcase
  endfunction
  // Reference: frame = 0x8000 + addr*256 + data; round-robin picks the pointer on contention
  function automatic void model(input int g, input logic [1:0] m, input logic [6:0] ad0, input logic [6:0] ad1,
                                input logic [7:0] dt0, input logic [7:0] dt1);
    int w;
    while (m != 2'b00) begin
      w = (m == 2'b11) ? int'(mptr[g]) : (m[1] ? 1 : 0);
      exp_fr.push_back(32768 + 256 * int'(w ? ad1 : ad0) + int'(w ? dt1 : dt0));
      exp_id.push_back(w);
      mreg[g][w ? ad1 : ad0] = w ? dt1 : dt0;
      mptr[g] = (w == 0);
      m[w] = 1'b0;
    end
  endfunction
  task automatic snap(input int g);
    bf = qs(g, 0);
    bgp = qs(g, 2);
    bd = qs(g, 3);
    bg = qs(g, 4);
  endtask
  task automatic req(input int g, input int i, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    if (g == 0) begin
      b0.req_addr[7*i +: 7] = a;
      b0.req_data[8*i +: 8] = d;
      b0.req_valid[i] = 1'b1;
    end else begin
      b1.req_addr[7*i +: 7] = a;
      b1.req_data[8*i +: 8] = d;
      b1.req_valid[i] = 1'b1;
    end
    #1;
    while (!(g ? b1.req_ready[i] : b0.req_ready[i]) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("req_ready_wait", 32'(n < 3000), 1);
    @(posedge clk);
    #1;
    if (g == 0) b0.req_valid[i] = 1'b0;
    else b1.req_valid[i] = 1'b0;
  endtask
  task automatic wait_fr(input int g, input int n);
    int c = 0;
    while (qs(g, 0) < n && c < 6000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("frame_wait", 32'(qs(g, 0) >= n), 1);
  endtask
  task automatic check_frames(input int g, input int n, input int cd);
    wait_fr(g, bf + n);
    for (int j = 0; j < n; j++) begin
      int e, id;
      e = exp_fr.pop_front();
      id = exp_id.pop_front();
      chk("frame", q(g, 0, bf + j), (16 << 16) | e);
      chk("ncs_low_len", q(g, 1, bf + j), 33 * cd);
      chk("done_id", q(g, 3, bd + j), id);
      chk("grant_id", q(g, 4, bg + j), id);
    end
    chk("done_count", qs(g, 3), bd + n);
    chk("grant_count", qs(g, 4), bg + n);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int bad, n, pm;
    logic [1:0] m;
    logic [6:0] ra0, ra1, a0[3], a1[3];
    logic [7:0] rd0, rd1, d0[3], d1[3];
    b0.req_valid = '0; b0.req_addr = '0; b0.req_data = '0;
    b1.req_valid = '0; b1.req_addr = '0; b1.req_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {b0.spi_nCS, b0.spi_sclk, b0.spi_copi, b0.busy, b0.done, b0.done_id, b0.req_ready}, 8'h80);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({b0.spi_nCS, b0.spi_sclk, b0.spi_copi, b0.busy, b0.done} !== 5'b10000) bad++;
    end
    chk("idle_hold_100", bad, 0);
    snap(0);
    @(negedge clk);
    b0.req_addr[6:0] = ADDR_PWM_DUTY;
    b0.req_data[7:0] = 8'hA5;
    b0.req_valid = 2'b01;
    #1;
    chk("a_ready_same_cycle", b0.req_ready, 2'b01);
    chk("a_ncs_before", b0.spi_nCS, 1);
    @(posedge clk);
    #1;
    b0.req_valid = 2'b00;
    chk("a_ncs_next_cycle", b0.spi_nCS, 0);
    chk("a_busy", b0.busy, 1);
    model(0, 2'b01, ADDR_PWM_DUTY, 7'h00, 8'hA5, 8'h00);
    check_frames(0, 1, 4);
    chk("a_raw_frame", q(0, 0, bf) & 32'hFFFF, 32'h84A5);
    chk("a_pwm_duty", mon[0].preg[ADDR_PWM_DUTY], 8'hA5);
    for (int k = 0; k < 3; k++) begin
      a0[k] = 7'($urandom); a1[k] = 7'($urandom);
      d0[k] = 8'($urandom); d1[k] = 8'($urandom);
    end
    snap(0);
    fork
      for (int k = 0; k < 3; k++) req(0, 0, a0[k], d0[k]);
      for (int k = 0; k < 3; k++) req(0, 1, a1[k], d1[k]);
    join
    for (int k = 0; k < 3; k++) model(0, 2'b11, a0[k], a1[k], d0[k], d1[k]);
    check_frames(0, 6, 4);
    chk("stream_first_grant_r1", q(0, 4, bg), 1);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr = '{1'b0, 1'b0};
    snap(0);
    fork
      req(0, 0, ADDR_EN_OUT_7_0, 8'hFF);
      req(0, 1, ADDR_EN_OUT_15_8, 8'h0F);
    join
    model(0, 2'b11, ADDR_EN_OUT_7_0, ADDR_EN_OUT_15_8, 8'hFF, 8'h0F);
    check_frames(0, 2, 4);
    chk("both_order_frame0", q(0, 0, bf) & 32'hFFFF, 32'h80FF);
    chk("both_order_frame1", q(0, 0, bf + 1) & 32'hFFFF, 32'h810F);
    chk("both_ncs_gap", q(0, 2, bgp + 1), 9);
    for (int r = 0; r < 6; r++) begin
      m = 2'($urandom_range(1, 3));
      ra0 = 7'($urandom); ra1 = 7'($urandom);
      rd0 = 8'($urandom); rd1 = 8'($urandom);
      snap(0);
      fork
        begin if (m[0]) req(0, 0, ra0, rd0); end
        begin if (m[1]) req(0, 1, ra1, rd1); end
      join
      model(0, m, ra0, ra1, rd0, rd1);
      check_frames(0, (m == 2'b11) ? 2 : 1, 4);
    end
    snap(0);
    req(0, 1, ADDR_EN_PWM_7_0, 8'h3C);
    @(negedge clk);
    #1;
    n = 0;
    while (mon[0].nbits < 7 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_reach_edge7", mon[0].nbits, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async_outputs", {b0.spi_nCS, b0.spi_sclk, b0.spi_copi, b0.busy, b0.done, b0.done_id, b0.req_ready}, 8'h80);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_no_done", qs(0, 3), bd);
    chk("abort_partial_bits", q(0, 0, bf) >> 16, 7);
    mptr = '{1'b0, 1'b0};
    snap(0);
    req(0, 0, ADDR_EN_PWM_15_8, 8'hC3);
    model(0, 2'b01, ADDR_EN_PWM_15_8, 7'h00, 8'hC3, 8'h00);
    check_frames(0, 1, 4);
    ra0 = 7'($urandom); ra1 = 7'($urandom);
    rd0 = 8'($urandom); rd1 = 8'($urandom);
    snap(1);
    fork
      req(1, 0, ra0, rd0);
      req(1, 1, ra1, rd1);
    join
    model(1, 2'b11, ra0, ra1, rd0, rd1);
    check_frames(1, 2, 2);
    chk("div2_ncs_gap", q(1, 2, bgp + 1), 2);
    repeat (20) @(negedge clk);
    pm = 0;
    for (int a = 0; a < 128; a++) begin
      if (mon[0].preg[a] !== mreg[0][a]) pm++;
      if (mon[1].preg[a] !== mreg[1][a]) pm++;
    end
    chk("peripheral_regs", pm, 0);
    chk("phase_len_dut0", mon[0].bad_phase, 0);
    chk("phase_len_dut1", mon[1].bad_phase, 0);
    chk("copi_stable_high", mon[0].bad_copi + mon[1].bad_copi, 0);
    chk("done_with_ncs_rise", mon[0].bad_done + mon[1].bad_done, 0);
    chk("ready_onehot_idle", mon[0].bad_ready + mon[1].bad_ready, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
